// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache with one word per line.
// Hit/miss counters saturate; flush invalidates every line when the cache is idle.
module data_cache #(
    parameter int unsigned SETS       = 8,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  stall,
    input  logic                  flush,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
);

    localparam int unsigned IDX_W = $clog2(SETS);
    localparam int unsigned TAG_W = ADDR_WIDTH - IDX_W - 2;
    localparam int unsigned CNT_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t                state;
    logic [SETS-1:0]       valid;
    logic [TAG_W-1:0]      tags  [SETS];
    logic [DATA_WIDTH-1:0] datas [SETS];

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic             hit;
    logic             hit_inc;
    logic             miss_inc;
    logic             unused_addr_lsb;

    assign idx             = cpu_addr[IDX_W+1:2];
    assign tag             = cpu_addr[ADDR_WIDTH-1:IDX_W+2];
    assign hit             = valid[idx] && (tags[idx] == tag);
    assign unused_addr_lsb = ^cpu_addr[1:0];

    assign mem_addr  = cpu_addr;
    assign mem_wdata = cpu_wdata;

    // Completion events: each retired access bumps exactly one counter.
    assign hit_inc  = ((state == IDLE) && cpu_req && !flush && !cpu_we && hit) ||
                      ((state == WRITE) && mem_ack && hit);
    assign miss_inc = ((state == FILL) && mem_ack) ||
                      ((state == WRITE) && mem_ack && !hit);

    // CPU/memory handshake decoded from state; ack-cycle read data is forwarded.
    always_comb begin
        stall     = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        cpu_rdata = datas[idx];
        unique case (state)
            IDLE: begin
                stall = cpu_req && (flush || cpu_we || !hit);
            end
            FILL: begin
                mem_req = 1'b1;
                stall   = !mem_ack;
                if (mem_ack) begin
                    cpu_rdata = mem_rdata;
                end
            end
            WRITE: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                stall   = !mem_ack;
            end
            default: begin
                stall = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            valid      <= '0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (flush) begin
                        valid <= '0;
                    end else if (cpu_req) begin
                        if (cpu_we) begin
                            state <= WRITE;
                        end else if (!hit) begin
                            state <= FILL;
                        end
                    end
                end
                FILL: begin
                    if (mem_ack) begin
                        valid[idx] <= 1'b1;
                        state      <= IDLE;
                    end
                end
                WRITE: begin
                    if (mem_ack) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
            if (hit_inc && (hit_count != '1)) begin
                hit_count <= hit_count + CNT_W'(1);
            end
            if (miss_inc && (miss_count != '1)) begin
                miss_count <= miss_count + CNT_W'(1);
            end
        end
    end

    // Tag/data arrays carry no reset; writes only happen on an ack outside IDLE.
    always_ff @(posedge clk) begin
        if ((state == FILL) && mem_ack) begin
            tags[idx]  <= tag;
            datas[idx] <= mem_rdata;
        end else if ((state == WRITE) && mem_ack && hit) begin
            datas[idx] <= cpu_wdata;
        end
    end

endmodule

// File: tb/tb_data_cache.sv
// Scoreboarded bench for data_cache: directed loads/stores against a bench memory
// model, with monitors popping expected load data and memory writes.
module tb_data_cache;

    logic        clk;
    logic        rst;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        stall;
    logic        flush;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    logic        ack_auto;
    logic        ack_stray;
    logic        ack_hold;
    int          ack_delay;
    int          wait_cnt;

    int          checks;
    int          errors;

    logic [31:0] mem_model [logic [31:0]];
    logic [31:0] rq[$];
    logic [63:0] wq[$];

    assign mem_ack = ack_auto | ack_stray;

    data_cache #(.SETS(8), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .stall     (stall),
        .flush     (flush),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .hit_count (hit_count),
        .miss_count(miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Backing memory: acks ack_delay cycles after mem_req rises, single-cycle pulse.
    always @(posedge clk) begin
        #1;
        if (ack_auto) begin
            ack_auto = 1'b0;
            wait_cnt = 0;
        end else if (mem_req && !ack_hold) begin
            if (wait_cnt >= ack_delay) begin
                ack_auto = 1'b1;
                wait_cnt = 0;
                if (mem_we) mem_model[mem_addr] = mem_wdata;
                else        mem_rdata = mem_model[mem_addr];
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    // Monitor: retired loads and completed memory writes are checked against the queues.
    always @(negedge clk) begin
        if (!rst && cpu_req && !cpu_we && !stall) begin
            if (rq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_load: got %h expected no load", cpu_rdata);
            end else begin
                check("load_data", cpu_rdata, rq.pop_front());
            end
        end
        if (mem_req && mem_we && mem_ack) begin
            if (wq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got %h expected no write", mem_addr);
            end else begin
                logic [63:0] w;
                w = wq.pop_front();
                check("write_addr", mem_addr, w[63:32]);
                check("write_data", mem_wdata, w[31:0]);
            end
        end
    end

    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          input int fl_lo, input int fl_hi, output int stalls);
        bit done;
        done = 1'b0;
        stalls = 0;
        @(posedge clk); #1;
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wd;
        for (int c = 0; c < 100 && !done; c++) begin
            flush = (c >= fl_lo) && (c < fl_hi);
            @(negedge clk);
            if (!stall) done = 1'b1;
            else        stalls++;
            @(posedge clk); #1;
        end
        cpu_req = 1'b0;
        cpu_we  = 1'b0;
        flush   = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL access_timeout: addr %h still stalled", addr);
        end
    endtask

    task automatic load(input string name, input logic [31:0] addr, input logic [31:0] exp,
                        input int exp_stalls, input int fl_lo, input int fl_hi);
        int s;
        rq.push_back(exp);
        access(1'b0, addr, 32'h0, fl_lo, fl_hi, s);
        check(name, 32'(s), 32'(exp_stalls));
    endtask

    task automatic store(input string name, input logic [31:0] addr, input logic [31:0] wd,
                         input int exp_stalls);
        int s;
        wq.push_back({addr, wd});
        access(1'b1, addr, wd, 0, 0, s);
        check(name, 32'(s), 32'(exp_stalls));
    endtask

    task automatic counts(input string name, input logic [31:0] h, input logic [31:0] m);
        check({name, "_hit"}, hit_count, h);
        check({name, "_miss"}, miss_count, m);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = 32'h0;
        cpu_wdata = 32'h0;
        flush     = 1'b0;
        mem_rdata = 32'h0;
        ack_auto  = 1'b0;
        ack_stray = 1'b0;
        ack_hold  = 1'b0;
        ack_delay = 0;
        wait_cnt  = 0;
        mem_model[32'h100] = 32'hDEADBEEF;
        mem_model[32'h120] = 32'h12345678;
        mem_model[32'h204] = 32'h0BADF00D;
        mem_model[32'h300] = 32'hCAFEF00D;

        repeat (2) @(negedge clk);
        check("rst_stall", 32'(stall), 32'h0);
        check("rst_mem_req", 32'(mem_req), 32'h0);
        counts("rst", 32'd0, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Cold miss with a 3-cycle memory wait, then a hit on the same line.
        ack_delay = 3;
        load("cold_stalls", 32'h100, 32'hDEADBEEF, 4, 0, 0);
        counts("cold", 32'd0, 32'd1);
        load("hit_stalls", 32'h100, 32'hDEADBEEF, 0, 0, 0);
        counts("hit", 32'd1, 32'd1);

        // Index conflict between 0x100 and 0x120.
        ack_delay = 1;
        load("conf_a_stalls", 32'h120, 32'h12345678, 2, 0, 0);
        load("conf_b_stalls", 32'h100, 32'hDEADBEEF, 2, 0, 0);
        counts("conflict", 32'd1, 32'd3);

        // Store hit updates the line; store miss leaves the line unallocated.
        store("st_hit_stalls", 32'h100, 32'h55AA55AA, 2);
        counts("st_hit", 32'd2, 32'd3);
        load("ld_after_st", 32'h100, 32'h55AA55AA, 0, 0, 0);
        counts("ld_after_st", 32'd3, 32'd3);
        store("st_miss_stalls", 32'h204, 32'h11112222, 2);
        counts("st_miss", 32'd3, 32'd4);
        load("ld_204_stalls", 32'h204, 32'h11112222, 2, 0, 0);
        counts("ld_204", 32'd3, 32'd5);

        // Flush together with a load of a cached line: one flush stall then a fill.
        ack_delay = 0;
        load("flush_ld_stalls", 32'h100, 32'h55AA55AA, 2, 0, 1);
        counts("flush_ld", 32'd3, 32'd6);

        // Flush held during FILL is ignored; the filled line then hits.
        ack_delay = 2;
        load("flush_fill_stalls", 32'h120, 32'h12345678, 3, 1, 4);
        load("after_flush_fill", 32'h120, 32'h12345678, 0, 0, 0);
        counts("flush_fill", 32'd4, 32'd7);

        // Reset in the middle of a fill, then a stray ack.
        ack_hold = 1'b1;
        @(posedge clk); #1;
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 32'h300;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("fill_mem_req", 32'(mem_req), 32'h1);
        #2 rst = 1'b1;
        #1;
        check("abort_mem_req", 32'(mem_req), 32'h0);
        check("abort_mem_we", 32'(mem_we), 32'h0);
        check("abort_stall_miss", 32'(stall), 32'h1);
        counts("abort", 32'd0, 32'd0);
        cpu_req = 1'b0;
        #1;
        check("abort_stall_idle", 32'(stall), 32'h0);
        @(posedge clk); #1;
        rst      = 1'b0;
        ack_hold = 1'b0;
        @(posedge clk); #1;
        ack_stray = 1'b1;
        @(posedge clk); #1;
        ack_stray = 1'b0;
        @(negedge clk);
        check("stray_mem_req", 32'(mem_req), 32'h0);
        counts("stray", 32'd0, 32'd0);
        ack_delay = 0;
        load("post_rst_stalls", 32'h100, 32'h55AA55AA, 1, 0, 0);
        counts("post_rst", 32'd0, 32'd1);
        load("post_rst_hit", 32'h100, 32'h55AA55AA, 0, 0, 0);
        counts("post_rst_hit", 32'd1, 32'd1);

        // Saturation of the hit counter.
        @(negedge clk);
        force dut.hit_count = 32'hFFFFFFFE;
        #1 release dut.hit_count;
        check("forced_hit", hit_count, 32'hFFFFFFFE);
        load("sat_a_stalls", 32'h100, 32'h55AA55AA, 0, 0, 0);
        check("sat_a_hit", hit_count, 32'hFFFFFFFF);
        load("sat_b_stalls", 32'h100, 32'h55AA55AA, 0, 0, 0);
        check("sat_b_hit", hit_count, 32'hFFFFFFFF);
        check("sat_miss", miss_count, 32'd1);

        repeat (2) @(posedge clk);
        check("rq_drained", 32'(rq.size()), 32'd0);
        check("wq_drained", 32'(wq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
